instr_fetch_unit: RTL and testbench

- Upstream front end of the multi-cycle CPU. It owns the PC, fetches one 32-bit instruction per instruction frame from instruction memory over a req/ack handshake, and holds it in the IR.
- It presents opcode[5:0] to the control unit, then waits out the execute frame.
- It computes the next PC from the control unit's 3-bit PC-source select plus the equ/les flags, and stops on HALT.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/instr_fetch_unit_next_pc.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU front end:
// PC-source selects, opcodes of interest and the fetch FSM state type.
package cpu_pkg;

    localparam logic [2:0] PCSRC_JUMP   = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JR     = 3'd2;
    localparam logic [2:0] PCSRC_SEQ    = 3'd3;
    localparam logic [2:0] PCSRC_HALT   = 3'd4;

    localparam logic [5:0] OP_HALT = 6'd0;
    localparam logic [5:0] OP_BEQ  = 6'd30;
    localparam logic [5:0] OP_BLT  = 6'd31;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection: jump, conditional branch, jump-register,
// sequential and halt. Purely combinational.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     instr,
    input  logic [2:0]      pc_sel,
    input  logic            equ,
    input  logic            les,
    input  logic [PC_W-1:0] reg_target,
    output logic [PC_W-1:0] next_pc,
    output logic            halt
);

    logic signed [15:0] imm16;
    logic [PC_W-1:0]    imm;
    logic [PC_W-1:0]    pc_seq;
    logic [PC_W-1:0]    pc_rel;
    logic [5:0]         op;
    logic               taken;
    logic               unused_bits;

    assign imm16       = instr[15:0];
    assign imm         = PC_W'(imm16);
    assign op          = opcode_of(instr);
    assign unused_bits = ^instr[25:16];

    // Both sums wrap modulo 2^PC_W by construction.
    assign pc_seq = pc + PC_W'(1);
    assign pc_rel = pc_seq + imm;

    assign taken = ((op == OP_BEQ) && equ)
                || ((op == OP_BLT) && les);

    always_comb begin
        next_pc = pc_seq;
        halt    = 1'b0;
        case (pc_sel)
            PCSRC_JUMP:   next_pc = pc_rel;
            PCSRC_BRANCH: next_pc = taken ? pc_rel : pc_seq;
            PCSRC_JR:     next_pc = reg_target;
            PCSRC_HALT: begin
                next_pc = pc;
                halt    = 1'b1;
            end
            default:      next_pc = pc_seq;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Front end of the multi-cycle CPU: owns the PC, fetches into the IR,
// holds it for one execute frame, then advances the PC or halts.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter int              EXEC_CYCLES = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [5:0]      opcode,
    output logic            ir_valid,
    output logic [PC_W-1:0] pc,
    input  logic [2:0]      pc_sel,
    input  logic            equ,
    input  logic            les,
    input  logic [PC_W-1:0] reg_target,
    output logic            halted
);

    localparam int CNT_W = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 2);

    fetch_state_e    state;
    fetch_state_e    state_n;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  pc_q;
    logic [31:0]      instr_q;
    logic             halted_q;
    logic             req_q;
    logic             accept;
    logic [PC_W-1:0]  next_pc;
    logic             halt;

    // Request is registered so a stale ack right after reset is dropped.
    assign accept = (state == ST_FETCH) && req_q && imem_ack;

    next_pc_calc #(
        .PC_W(PC_W)
    ) u_next_pc (
        .pc         (pc_q),
        .instr      (instr_q),
        .pc_sel     (pc_sel),
        .equ        (equ),
        .les        (les),
        .reg_target (reg_target),
        .next_pc    (next_pc),
        .halt       (halt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            cnt      <= '0;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state <= state_n;
            req_q <= (state_n == ST_FETCH);
            if (accept) begin
                instr_q <= imem_rdata;
                cnt     <= '0;
            end
            if (state == ST_EXEC) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_UPDATE) begin
                pc_q <= next_pc;
                if (halt) begin
                    halted_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_FETCH:  if (accept) state_n = ST_EXEC;
            ST_EXEC:   if (cnt == CNT_LAST) state_n = ST_UPDATE;
            ST_UPDATE: state_n = halt ? ST_HALT : ST_FETCH;
            ST_HALT:   state_n = ST_HALT;
            default:   state_n = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = req_q;
        imem_addr = pc_q;
        instr     = instr_q;
        opcode    = opcode_of(instr_q);
        ir_valid  = (state == ST_EXEC) || (state == ST_UPDATE);
        pc        = pc_q;
        halted    = halted_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch handshake, frame length,
// next-PC selection and wrap, halt and reset behaviour.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        ir_valid;
    logic [15:0] pc;
    logic [2:0]  pc_sel;
    logic        equ;
    logic        les;
    logic [15:0] reg_target;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .pc_sel     (pc_sel),
        .equ        (equ),
        .les        (les),
        .reg_target (reg_target),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full instruction: wait for request, ack after wait_cyc extra
    // request cycles, then measure the frame with ir_valid.
    task automatic run_instr(input string tag, input logic [15:0] addr,
                             input logic [31:0] word, input int wait_cyc,
                             input logic [2:0] sel, input logic e,
                             input logic l, input logic [15:0] tgt,
                             input bit stray);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, 32'(imem_addr), 32'(addr));
        repeat (wait_cyc) @(negedge clk);
        check({tag, "_hold"}, 32'(imem_req), 32'd1);
        pc_sel     = sel;
        equ        = e;
        les        = l;
        reg_target = tgt;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check({tag, "_op"}, 32'(opcode), 32'(word[31:26]));
        check({tag, "_pc"}, 32'(pc), 32'(addr));
        n = 0;
        while (ir_valid && n < 20) begin
            if (stray && n == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = '0;
            end
            n++;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check({tag, "_len"}, 32'(n), 32'd8);
        check({tag, "_ir"}, instr, word);
    endtask

    initial begin
        int hits;
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        pc_sel     = 3'd3;
        equ        = 1'b0;
        les        = 1'b0;
        reg_target = '0;
        repeat (3) @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ir", instr, 32'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_irv", 32'(ir_valid), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        rst_n = 1'b1;

        run_instr("t1", 16'h0000, 32'h0C00_0000, 3, 3'd3, 0, 0, 16'h0, 0);
        run_instr("jr5a", 16'h0001, 32'h0400_0000, 0, 3'd2, 0, 0, 16'h5, 1);
        run_instr("beq_t", 16'h0005, 32'h7800_FFFD, 1, 3'd1, 1, 0, 16'h0, 0);
        run_instr("jr5b", 16'h0003, 32'h0400_0000, 0, 3'd2, 0, 0, 16'h5, 0);
        run_instr("beq_n", 16'h0005, 32'h7800_FFFD, 0, 3'd1, 0, 1, 16'h0, 0);
        run_instr("jr5c", 16'h0006, 32'h0400_0000, 2, 3'd2, 0, 0, 16'h5, 0);
        run_instr("blt", 16'h0005, 32'h7C00_0004, 0, 3'd1, 0, 1, 16'h0, 0);
        run_instr("jr1234", 16'h000A, 32'h0400_0000, 0, 3'd2, 0, 0, 16'h1234, 0);
        run_instr("jrffff", 16'h1234, 32'h0400_0000, 0, 3'd2, 0, 0, 16'hFFFF, 0);
        run_instr("jwrap", 16'hFFFF, 32'h0800_0001, 0, 3'd0, 0, 0, 16'h0, 0);
        run_instr("jrffff2", 16'h0001, 32'h0400_0000, 0, 3'd2, 0, 0, 16'hFFFF, 0);
        run_instr("seqwrap", 16'hFFFF, 32'h0C00_0000, 0, 3'd3, 0, 0, 16'h0, 0);
        run_instr("sel7", 16'h0000, 32'h0C00_0000, 0, 3'd7, 0, 0, 16'h0, 0);
        run_instr("halt", 16'h0001, 32'h0000_0000, 0, 3'd4, 0, 0, 16'h0, 0);

        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'h1);
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            if (imem_req || ir_valid) hits++;
            @(negedge clk);
        end
        check("halt_idle", 32'(hits), 32'd0);
        check("halt_pc2", 32'(pc), 32'h1);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_pc", 32'(pc), 32'h0);
        check("rst2_halt", 32'(halted), 32'd0);
        check("rst2_ir", instr, 32'h0);

        hits = 0;
        while (!imem_req && hits < 20) begin
            @(negedge clk);
            hits++;
        end
        check("mid_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_drop", 32'(imem_req), 32'd0);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("late_ir", instr, 32'h0);
        check("late_req", 32'(imem_req), 32'd1);
        check("late_addr", 32'(imem_addr), 32'h0);

        run_instr("post", 16'h0000, 32'h0C00_0000, 0, 3'd3, 0, 0, 16'h0, 0);
        hits = 0;
        while (!imem_req && hits < 20) begin
            @(negedge clk);
            hits++;
        end
        check("post_addr", 32'(imem_addr), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
